// File: rtl/binary_bcd_seq_display.sv
// rtl/binary_bcd_seq_display.sv - multi-cycle double-dabble binary-to-BCD converter with 7-segment decode
// One input bit is consumed per clock; the result and its active-low segments are held between conversions.
module binary_bcd_seq_display #(
   parameter int WIDTH         = 10,
   parameter int DIGITS        = 4,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   hex_out
);

   // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
   function automatic bit digits_fit(input int w, input int d);
      longint lim;
      longint p;
      lim = (longint'(1) << w) - 1;
      p   = 1;
      for (int i = 0; i < d; i++) begin
         if (p <= lim) p = p * 10;
      end
      return p > lim;
   endfunction

   generate
      if (WIDTH < 1 || WIDTH > 32 || DIGITS < 1 || !digits_fit(WIDTH, DIGITS)) begin : g_param_check
         $error("binary_bcd_seq_display: illegal WIDTH/DIGITS combination");
      end
   endgenerate

   localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      shreg_q, shreg_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [CW-1:0]         count_q, count_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  done_q, done_d;

   logic [4*DIGITS-1:0]   scratch_adj;
   logic [4*DIGITS-1:0]   scratch_shift;

   // Add-3 correction on every digit, then the next binary bit enters the units digit.
   always_comb begin
      scratch_adj = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
      scratch_shift = {scratch_adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      bcd_d     = bcd_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d   = bin_in;
               scratch_d = '0;
               count_d   = '0;
               state_d   = S_CONV;
            end
         end
         S_CONV: begin
            scratch_d = scratch_shift;
            shreg_d   = shreg_q << 1;
            count_d   = count_q + 1'b1;
            if (count_q == LAST_COUNT) begin
               bcd_d   = scratch_shift;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         bcd_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         bcd_q     <= bcd_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == S_CONV);
   assign done    = done_q;
   assign bcd_out = bcd_q;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic lead_zero;

   // Walk from the most significant digit down; digit 0 is never blanked.
   always_comb begin
      hex_out   = '1;
      lead_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lead_zero = lead_zero && (bcd_q[4*k +: 4] == 4'd0);
         if (BLANK_LEADING && (k > 0) && lead_zero) begin
            hex_out[7*k +: 7] = 7'b1111111;
         end else begin
            hex_out[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
         end
      end
   end

endmodule

// File: tb/tb_binary_bcd_seq_display.sv
// tb/tb_binary_bcd_seq_display.sv - self-checking bench for binary_bcd_seq_display
module tb_binary_bcd_seq_display;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [9:0]  bin;
   logic        start6;
   logic [5:0]  bin6;

   logic        busy, done, busy_nb, done_nb, busy6, done6;
   logic [15:0] bcd, bcd_nb;
   logic [27:0] hex, hex_nb;
   logic [7:0]  bcd6;
   logic [13:0] hex6;

   int checks = 0;
   int errors = 0;

   binary_bcd_seq_display #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(1'b1)) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .bin_in(bin),
      .busy(busy), .done(done), .bcd_out(bcd), .hex_out(hex));

   binary_bcd_seq_display #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(1'b0)) dut_nb (
      .CLOCK_50(clk), .reset(reset), .start(start), .bin_in(bin),
      .busy(busy_nb), .done(done_nb), .bcd_out(bcd_nb), .hex_out(hex_nb));

   binary_bcd_seq_display #(.WIDTH(6), .DIGITS(2), .BLANK_LEADING(1'b1)) dut6 (
      .CLOCK_50(clk), .reset(reset), .start(start6), .bin_in(bin6),
      .busy(busy6), .done(done6), .bcd_out(bcd6), .hex_out(hex6));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [63:0] model_bcd(input int v, input int nd);
      logic [63:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < nd; k++) begin
         r = r | (64'((v / p) % 10) << (4 * k));
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] model_hex(input int v, input int nd, input bit blank);
      logic [63:0] r;
      logic [6:0]  s;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < nd; k++) begin
         if (blank && k > 0 && v < p) s = 7'b1111111;
         else s = seg_of((v / p) % 10);
         r = r | (64'(s) << (7 * k));
         p = p * 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_conv(input bit six, input int value);
      int busy_cnt;
      int n;
      int changed;
      int w;
      int nd;
      bit seen;
      logic [63:0] prev;
      w        = six ? 6 : 10;
      nd       = six ? 2 : 4;
      prev     = six ? 64'(bcd6) : 64'(bcd);
      busy_cnt = 0;
      changed  = 0;
      seen     = 1'b0;
      n        = 0;
      if (six) begin
         start6 = 1'b1;
         bin6   = value[5:0];
      end else begin
         start  = 1'b1;
         bin    = value[9:0];
      end
      tick();
      start  = 1'b0;
      start6 = 1'b0;
      bin    = '0;
      bin6   = '0;
      while (!seen && n < 40) begin
         if (six ? done6 : done) begin
            seen = 1'b1;
         end else begin
            if (six ? busy6 : busy) busy_cnt++;
            if ((six ? 64'(bcd6) : 64'(bcd)) !== prev) changed++;
            tick();
            n++;
         end
      end
      check("done_seen", 64'(seen), 64'(1));
      check("busy_cycles", 64'(busy_cnt), 64'(w));
      check("bcd_held_during_conv", 64'(changed), 64'(0));
      check("busy_low_at_done", 64'(six ? busy6 : busy), 64'(0));
      check("bcd_result", six ? 64'(bcd6) : 64'(bcd), model_bcd(value, nd));
      check("hex_result", six ? 64'(hex6) : 64'(hex), model_hex(value, nd, 1'b1));
      if (!six) begin
         check("bcd_result_noblank", 64'(bcd_nb), model_bcd(value, 4));
         check("hex_result_noblank", 64'(hex_nb), model_hex(value, 4, 1'b0));
      end
      tick();
      check("done_single_cycle", 64'(six ? done6 : done), 64'(0));
   endtask

   initial begin
      int dones;
      int first_done;
      int second_done;
      int bad;
      logic [15:0] got;
      logic [15:0] got2;

      reset  = 1'b1;
      start  = 1'b0;
      start6 = 1'b0;
      bin    = '0;
      bin6   = '0;
      tick();
      tick();
      reset = 1'b0;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_bcd", 64'(bcd), 64'(0));
      check("reset_hex", 64'(hex), model_hex(0, 4, 1'b1));
      check("reset_hex_noblank", 64'(hex_nb), model_hex(0, 4, 1'b0));
      check("reset_hex6", 64'(hex6), model_hex(0, 2, 1'b1));

      run_conv(1'b0, 1023);
      check("bcd_1023", 64'(bcd), 64'(16'h1023));
      check("hex_1023", 64'(hex), 64'({7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110}));
      run_conv(1'b0, 7);
      check("hex_7", 64'(hex), 64'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}));
      check("hex_7_noblank", 64'(hex_nb), 64'({7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}));
      run_conv(1'b0, 0);
      run_conv(1'b1, 63);
      check("hex6_63", 64'(hex6), 64'({7'b0100000, 7'b0000110}));
      run_conv(1'b1, 0);
      check("bcd6_0", 64'(bcd6), 64'(0));

      for (int i = 0; i < 12; i++) run_conv(1'b0, int'($urandom_range(0, 1023)));
      for (int i = 0; i < 6; i++) run_conv(1'b1, int'($urandom_range(0, 63)));

      // start while busy must be ignored
      start = 1'b1;
      bin   = 10'd500;
      tick();
      start = 1'b0;
      bin   = '0;
      for (int i = 0; i < 3; i++) tick();
      start = 1'b1;
      bin   = 10'd999;
      tick();
      start = 1'b0;
      bin   = '0;
      dones = 0;
      got   = '0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            got = bcd;
         end
         tick();
      end
      check("busy_start_done_count", 64'(dones), 64'(1));
      check("busy_start_result", 64'(got), 64'(16'h0500));
      check("busy_start_idle", 64'(busy), 64'(0));

      // start held high: one conversion per WIDTH+1 cycles
      start       = 1'b1;
      bin         = 10'd100;
      tick();
      bin         = 10'd200;
      first_done  = -1;
      second_done = -1;
      bad         = 0;
      got         = '0;
      got2        = '0;
      for (int i = 1; i <= 21; i++) begin
         tick();
         if (bcd !== 16'h0500 && bcd !== 16'h0100 && bcd !== 16'h0200) bad++;
         if (done) begin
            if (first_done < 0) begin
               first_done = i;
               got        = bcd;
            end else if (second_done < 0) begin
               second_done = i;
               got2        = bcd;
            end else begin
               bad++;
            end
         end
      end
      start = 1'b0;
      bin   = '0;
      check("held_first_done", 64'(first_done), 64'(10));
      check("held_second_done", 64'(second_done), 64'(21));
      check("held_first_bcd", 64'(got), 64'(16'h0100));
      check("held_second_bcd", 64'(got2), 64'(16'h0200));
      check("held_no_stray", 64'(bad), 64'(0));
      dones = 0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (done) dones++;
      end
      check("held_stop", 64'(dones), 64'(0));

      // reset mid-conversion aborts it
      start = 1'b1;
      bin   = 10'd1000;
      tick();
      start = 1'b0;
      bin   = '0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_bcd", 64'(bcd), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_hex", 64'(hex), model_hex(0, 4, 1'b1));
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dones++;
         tick();
      end
      check("abort_no_done", 64'(dones), 64'(0));
      run_conv(1'b0, 1000);
      check("after_abort_bcd", 64'(bcd), 64'(16'h1000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
